dtmf_digit_validator: RTL and testbench

// Downstream stage of the tone lookup. Consumes one 16-bit tone code per analysis frame (strobed by upstream done).

---
 rtl/dtmf_pkg.sv | 12 +
 rtl/dtmf_digit_fifo.sv | 44 ++++
 rtl/dtmf_digit_validator.sv | 136 +++++++++++++
 tb/tb_dtmf_digit_validator.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dtmf_pkg.sv
// dtmf_pkg: shared tone codes, digit type and validator FSM states.
package dtmf_pkg;
    localparam logic [15:0] NO_TONE = 16'hFFFF;
    typedef logic [3:0] dtmf_code_t;
    localparam dtmf_code_t CODE_A    = 4'd10;
    localparam dtmf_code_t CODE_B    = 4'd11;
    localparam dtmf_code_t CODE_C    = 4'd12;
    localparam dtmf_code_t CODE_D    = 4'd13;
    localparam dtmf_code_t CODE_STAR = 4'd14;
    localparam dtmf_code_t CODE_HASH = 4'd15;
    typedef enum logic [1:0] {IDLE, CAND, HELD} state_t;
endpackage

// File: rtl/dtmf_digit_fifo.sv
// dtmf_digit_fifo: small digit FIFO with registered pointers and sticky overflow.
module dtmf_digit_fifo
    import dtmf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear_ovf,
    input  dtmf_code_t               din,
    output dtmf_code_t               dout,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, do_pop, do_push;
    dtmf_code_t  mem [DEPTH];

    // Extra pointer MSB tells full from empty when the index bits match.
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            overflow <= (push && !do_push) ? 1'b1 : clear_ovf ? 1'b0 : overflow;
        end

    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/dtmf_digit_validator.sv
// dtmf_digit_validator: debounces per-frame tone codes into single digit presses queued in a FIFO.
// Optional DTMF_SEQ_END_EN adds a seq_end pulse after a run of silent frames following a digit.
module dtmf_digit_validator
    import dtmf_pkg::*;
#(
    parameter int ON_FRAMES      = 3,
    parameter int OFF_FRAMES     = 2,
    parameter int DEPTH          = 8,
    parameter int SEQ_END_FRAMES = 25
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     tone_valid,
    input  logic [15:0]              tone,
    input  logic                     tone_error,
    output logic [3:0]               digit,
    output logic                     digit_valid,
    input  logic                     digit_ready,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     seq_end
);
    localparam int CMAX = ON_FRAMES > OFF_FRAMES ? ON_FRAMES : OFF_FRAMES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C1    = CW'(1);
    localparam logic [CW-1:0] ON_C  = CW'(ON_FRAMES);
    localparam logic [CW-1:0] OFF_C = CW'(OFF_FRAMES);

    if (ON_FRAMES < 1 || OFF_FRAMES < 1 || DEPTH < 2 || SEQ_END_FRAMES < 1) begin : g_bad_param
        $error("dtmf_digit_validator: invalid parameter");
    end

    state_t     state, nxt_state;
    dtmf_code_t cand, nxt_cand, code;
    logic [CW-1:0] cnt, nxt_cnt, cnt_inc;
    logic silent, push, empty;

    assign code    = tone[3:0];
    assign silent  = tone_error || tone == NO_TONE || tone > 16'd15;
    assign cnt_inc = cnt + C1;

    always_comb begin
        nxt_state = state;
        nxt_cand  = cand;
        nxt_cnt   = cnt;
        push      = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
        end else if (tone_valid)
            case (state)
                IDLE: if (!silent) begin
                    nxt_cand = code;
                    if (ON_FRAMES == 1) begin
                        push      = 1'b1;
                        nxt_state = HELD;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_state = CAND;
                        nxt_cnt   = C1;
                    end
                end
                CAND: if (silent) begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end else if (code != cand) begin
                    nxt_cand = code;
                    nxt_cnt  = C1;
                end else if (cnt_inc == ON_C) begin
                    push      = 1'b1;
                    nxt_state = HELD;
                    nxt_cnt   = '0;
                end else
                    nxt_cnt = cnt_inc;
                HELD: begin
                    nxt_cnt   = !silent ? '0 : (cnt_inc == OFF_C) ? '0 : cnt_inc;
                    nxt_state = (silent && cnt_inc == OFF_C) ? IDLE : HELD;
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
            endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cand  <= nxt_cand;
            cnt   <= nxt_cnt;
        end

    // Pushed value equals cand on the accepting frame, so the live code is used.
    dtmf_digit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (digit_valid && digit_ready),
        .clear_ovf (clear_ovf),
        .din       (code),
        .dout      (digit),
        .empty     (empty),
        .overflow  (overflow),
        .count     (fill_level)
    );
    assign digit_valid = !empty;

`ifdef DTMF_SEQ_END_EN
    localparam int SW = $clog2(SEQ_END_FRAMES + 1);
    localparam logic [SW-1:0] SEQ_C = SW'(SEQ_END_FRAMES);
    logic [SW-1:0] sq_cnt;
    logic armed, sq_run, sq_hit;

    assign sq_run = enable && tone_valid && silent && state == IDLE && armed && sq_cnt != SEQ_C;
    assign sq_hit = sq_run && sq_cnt == SEQ_C - 1'b1;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            sq_cnt  <= '0;
            armed   <= 1'b0;
            seq_end <= 1'b0;
        end else begin
            sq_cnt  <= (!enable || (tone_valid && !silent)) ? '0 : sq_run ? sq_cnt + 1'b1 : sq_cnt;
            armed   <= push ? 1'b1 : sq_hit ? 1'b0 : armed;
            seq_end <= sq_hit;
        end
`else
    assign seq_end = 1'b0;
`endif
endmodule

// File: tb/tb_dtmf_digit_validator.sv
// tb_dtmf_digit_validator: directed checks of debounce, FIFO, overflow, enable and reset behaviour.
module tb_dtmf_digit_validator;
    import dtmf_pkg::*;
    logic        clock = 1'b0, reset = 1'b0, enable = 1'b1;
    logic        tone_valid = 1'b0, tone_error = 1'b0, digit_ready = 1'b0, clear_ovf = 1'b0;
    logic [15:0] tone = NO_TONE;
    logic [3:0]  digit;
    logic        digit_valid, overflow, seq_end;
    logic [3:0]  fill_level;
    int          n_chk = 0, n_pass = 0;

    dtmf_digit_validator dut (
        .clock(clock), .reset(reset), .enable(enable), .tone_valid(tone_valid),
        .tone(tone), .tone_error(tone_error), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .overflow(overflow), .clear_ovf(clear_ovf),
        .fill_level(fill_level), .seq_end(seq_end)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic frame(input logic [15:0] t, input logic e = 1'b0);
        tone = t; tone_error = e; tone_valid = 1'b1;
        @(posedge clock); #1;
        tone_valid = 1'b0; tone_error = 1'b0; tone = NO_TONE;
    endtask

    task automatic silence(input int n);
        for (int i = 0; i < n; i++) frame(NO_TONE);
    endtask

    task automatic press(input logic [15:0] c);
        for (int i = 0; i < 3; i++) frame(c);
        silence(2);
    endtask

    task automatic pop_chk(input logic [3:0] exp);
        chk("pop_valid", digit_valid, 1);
        chk("pop_head", digit, exp);
        digit_ready = 1'b1;
        @(posedge clock); #1;
        digit_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", digit_valid, 0);
        chk("rst_digit", digit, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_seq_end", seq_end, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        frame(16'd5); frame(16'd5);
        chk("five_early", digit_valid, 0);
        frame(16'd5);
        chk("five_valid", digit_valid, 1);
        chk("five_fill", fill_level, 1);
        silence(2);
        pop_chk(4'd5);
        chk("five_drained", fill_level, 0);

        frame(16'd5); frame(16'd5); frame(NO_TONE);
        chk("bounce_nopush", fill_level, 0);
        frame(16'd5); frame(16'd5); frame(16'd5);
        silence(2);
        chk("bounce_fill", fill_level, 1);
        pop_chk(4'd5);

        for (int i = 0; i < 10; i++) frame(16'd7);
        silence(2);
        chk("long7_fill", fill_level, 1);
        pop_chk(4'd7);

        for (int i = 0; i < 3; i++) frame(16'd3);
        for (int i = 0; i < 3; i++) frame(16'd9);
        chk("held_fill", fill_level, 1);
        silence(2);
        press(16'd9);
        chk("rearm_fill", fill_level, 2);
        pop_chk(4'd3);
        pop_chk(4'd9);

        for (int i = 0; i < 3; i++) frame(16'd4, 1'b1);
        chk("err_nopush", fill_level, 0);
        for (int i = 0; i < 3; i++) frame(16'h0011);
        chk("range_nopush", fill_level, 0);

        frame(16'd6); frame(16'd6);
        enable = 1'b0; tone_valid = 1'b1; tone = 16'd6;
        @(posedge clock); #1;
        tone_valid = 1'b0; tone = NO_TONE; enable = 1'b1;
        frame(16'd6); frame(16'd6);
        chk("en_restart", fill_level, 0);
        frame(16'd6);
        chk("en_push", fill_level, 1);
        silence(2);
        pop_chk(4'd6);

        for (int c = 0; c < 9; c++) press(16'(c));
        chk("full_fill", fill_level, 8);
        chk("full_ovf", overflow, 1);
        chk("full_head", digit, 0);
        clear_ovf = 1'b1;
        @(posedge clock); #1;
        clear_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);
        frame(16'd9); frame(16'd9);
        digit_ready = 1'b1;
        frame(16'd9);
        digit_ready = 1'b0;
        chk("pushpop_fill", fill_level, 8);
        chk("pushpop_ovf", overflow, 0);
        silence(2);
        for (int i = 1; i < 8; i++) pop_chk(4'(i));
        pop_chk(4'd9);
        chk("fifo_empty", digit_valid, 0);

        press(16'd1); press(16'd2);
        chk("pre_rst_fill", fill_level, 2);
        frame(16'd4); frame(16'd4);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", digit_valid, 0);
        chk("mid_rst_fill", fill_level, 0);
        chk("mid_rst_digit", digit, 0);
        chk("mid_rst_ovf", overflow, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        frame(16'd4);
        chk("post_rst_nopush", fill_level, 0);
        frame(16'd4); frame(16'd4);
        chk("post_rst_push", fill_level, 1);
        silence(2);
        pop_chk(4'd4);

`ifdef DTMF_SEQ_END_EN
        begin
            int pulses = 0;
            for (int i = 0; i < 3; i++) frame(16'd8);
            for (int i = 0; i < 40; i++) begin
                frame(NO_TONE);
                pulses += int'(seq_end);
            end
            chk("seq_end_pulses", pulses, 1);
            pop_chk(4'd8);
        end
`else
        chk("seq_end_tied", seq_end, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
